// File: rtl/str_arb.sv
// N-to-1 round-robin AXI4-stream arbiter with optional packet-locked grant.
// One IDLE cycle arbitrates; XFER muxes the granted source straight to the sink.
module str_arb #(
  parameter int N    = 4,
  parameter int VW   = 32,
  parameter int LOCK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      s_tvalid,
  output logic [N-1:0]      s_tready,
  input  logic [N*VW-1:0]   s_tvalue,
  input  logic [N-1:0]      s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [VW-1:0]     m_tvalue,
  output logic              m_tlast,
  output logic [N-1:0]      grant,
  output logic              busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            xfer;
  logic            rel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

  // Handshake: a beat moves on a rising edge where m_tvalid and m_tready are
  // both high; the granted source sees s_tready = m_tready, all others see 0.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;

    // Search ptr, ptr+1, ... wrapping, so the port after the last winner leads.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!found && s_tvalid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    m_tvalid = 1'b0;
    m_tvalue = '0;
    m_tlast  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        m_tvalid = s_tvalid[i];
        m_tvalue = s_tvalue[i*VW +: VW];
        m_tlast  = s_tlast[i];
      end
    end
    s_tready = grant_q & {N{m_tready}};

    xfer = m_tvalid & m_tready;
    rel  = xfer & ((LOCK == 0) || m_tlast);

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          grant_d = N'(1) << win;
          gidx_d  = win;
        end
      end
      XFER: begin
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q == XFER);

endmodule
